// File: rtl/definitions_pkg.sv
// Shared types and constants for the convolution output write path.
// The coalescer defaults its parameters to the constants declared here.
package definitions_pkg;

  localparam int unsigned COMPUTING_GROUP_SIZE = 16;
  localparam int unsigned FEATURE_W            = 8;
  localparam int unsigned MEM_ADDR_W           = 32;
  localparam int unsigned WRC_DEPTH            = 8;
  localparam int unsigned WRC_MAX_BURST        = 4;
  localparam int unsigned WRC_ACK_W            = 4;

  typedef logic [FEATURE_W-1:0]              s_feature_t;
  typedef logic [MEM_ADDR_W-1:0]             mem_addr_t;
  typedef logic [$clog2(WRC_MAX_BURST)-1:0]  burst_len_t;

  typedef enum logic [1:0] {
    WRC_IDLE,
    WRC_REQ,
    WRC_DATA
  } wrc_state_t;

  typedef struct packed {
    mem_addr_t                                addr;
    s_feature_t [COMPUTING_GROUP_SIZE-1:0]    data;
    logic                                     inst;
  } wrc_entry_t;

  // An address that starts a new MAX_BURST-aligned block may not join a run.
  function automatic logic isBurstBoundary(input mem_addr_t a);
    return a[$clog2(WRC_MAX_BURST)-1:0] == '0;
  endfunction

endpackage

// File: rtl/conv_wr_fifo.sv
// Synchronous FIFO of write-coalescer entries with an occupancy count and
// a look-ahead view of the first PEEK entries starting at the head.
module conv_wr_fifo
  import definitions_pkg::*;
#(
  parameter int unsigned DEPTH = WRC_DEPTH,
  parameter int unsigned PEEK  = WRC_MAX_BURST
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    pushEn,
  input  wrc_entry_t              pushEntry,
  input  logic                    popEn,
  output logic [$clog2(DEPTH):0]  count,
  output wrc_entry_t              peek [PEEK]
);

  localparam int unsigned PW = $clog2(DEPTH);

  wrc_entry_t    mem [DEPTH];
  logic [PW-1:0] rdPtr;
  logic [PW-1:0] wrPtr;
  logic          full;
  logic          empty;
  logic          doPush;
  logic          doPop;

  assign full   = count == (PW+1)'(DEPTH);
  assign empty  = count == '0;
  assign doPop  = popEn && !empty;
  // A pop in the same cycle frees the slot, so a push at full is still accepted.
  assign doPush = pushEn && (!full || doPop);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      count <= count + (PW+1)'(doPush) - (PW+1)'(doPop);
    end
  end

  always_ff @(posedge clock) begin
    if (doPush) mem[wrPtr] <= pushEntry;
  end

  always_comb begin
    for (int unsigned i = 0; i < PEEK; i++) begin
      peek[i] = mem[rdPtr + PW'(i)];
    end
  end

endmodule

// File: rtl/conv_out_write_coalescer.sv
// Buffers convolution output beats and merges consecutive addresses into
// memory write bursts. Define CONV_WR_COALESCE_EN to enable run coalescing.
module conv_out_write_coalescer
  import definitions_pkg::*;
#(
  parameter int unsigned CG_SIZE   = COMPUTING_GROUP_SIZE,
  parameter int unsigned FEAT_W    = FEATURE_W,
  parameter int unsigned ADDR_W    = MEM_ADDR_W,
  parameter int unsigned DEPTH     = WRC_DEPTH,
  parameter int unsigned MAX_BURST = WRC_MAX_BURST,
  parameter int unsigned ACK_W     = WRC_ACK_W
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          pwrite_enable,
  input  logic [ADDR_W-1:0]             pwrite_addr,
  input  logic [CG_SIZE*FEAT_W-1:0]     pwrite_data,
  input  logic                          pwrite_setNextInst,
  output logic                          pwrite_isWritable,
  output logic                          mem_req_valid,
  input  logic                          mem_req_ready,
  output logic [ADDR_W-1:0]             mem_req_addr,
  output logic [$clog2(MAX_BURST)-1:0]  mem_req_len,
  output logic                          mem_wdata_valid,
  input  logic                          mem_wdata_ready,
  output logic [CG_SIZE*FEAT_W-1:0]     mem_wdata,
  output logic                          mem_wdata_last,
  input  logic                          mem_wr_ack,
  output logic                          inst_done,
  output logic                          busy
);

  localparam int unsigned LB = $clog2(MAX_BURST);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
`ifdef CONV_WR_COALESCE_EN
  localparam int unsigned SCAN = MAX_BURST;
`else
  localparam int unsigned SCAN = 1;
`endif

  wrc_state_t       state;
  wrc_state_t       nextState;
  wrc_entry_t       pushEntry;
  wrc_entry_t       peek [SCAN];
  logic [CW-1:0]    fifoCount;
  logic             fifoEmpty;
  logic             runFinal;
  burst_len_t       runLen;
  mem_addr_t        reqAddr;
  burst_len_t       reqLen;
  burst_len_t       beatCnt;
  logic [ACK_W-1:0] outstanding;
  logic             fence;
  logic             startReq;
  logic             reqFire;
  logic             wdataFire;
  logic             lastBeat;
  logic             ackAccepted;
  logic             instDone;

  assign pushEntry = '{addr: pwrite_addr, data: pwrite_data, inst: pwrite_setNextInst};

  conv_wr_fifo #(
    .DEPTH (DEPTH),
    .PEEK  (SCAN)
  ) uFifo (
    .clock     (clock),
    .reset     (reset),
    .pushEn    (pwrite_enable),
    .pushEntry (pushEntry),
    .popEn     (wdataFire),
    .count     (fifoCount),
    .peek      (peek)
  );

  assign fifoEmpty         = fifoCount == '0;
  assign pwrite_isWritable = fifoCount < CW'(DEPTH);

`ifdef CONV_WR_COALESCE_EN
  logic [LB:0] run;
  logic        lastInst;
  logic        scanStop;

  // Contiguous, non-boundary-crossing head entries, ending at an instruction's last beat.
  always_comb begin
    run      = '0;
    lastInst = 1'b0;
    scanStop = 1'b0;
    for (int unsigned i = 0; i < SCAN; i++) begin
      if (!scanStop && CW'(i) < fifoCount &&
          (i == 0 || (peek[i].addr == peek[0].addr + ADDR_W'(i) &&
                      !isBurstBoundary(peek[i].addr)))) begin
        run      = (LB+1)'(i + 1);
        lastInst = peek[i].inst;
        scanStop = peek[i].inst;
      end else begin
        scanStop = 1'b1;
      end
    end
  end

  // Wait for a run to grow only while another contiguous beat may still arrive.
  assign runFinal = (run == (LB+1)'(MAX_BURST)) || (CW'(run) < fifoCount) ||
                    lastInst || !pwrite_enable;
  assign runLen   = LB'(run - 1'b1);
`else
  assign runFinal = 1'b1;
  assign runLen   = '0;
`endif

  assign startReq    = (state == WRC_IDLE) && !fifoEmpty && !fence && runFinal &&
                       (outstanding != '1);
  assign reqFire     = (state == WRC_REQ) && mem_req_ready;
  assign wdataFire   = (state == WRC_DATA) && mem_wdata_ready;
  assign lastBeat    = beatCnt == reqLen;
  assign ackAccepted = mem_wr_ack && (outstanding != '0);
  assign instDone    = (state == WRC_IDLE) && fence && (outstanding == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= WRC_IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      WRC_IDLE: if (startReq)                    nextState = WRC_REQ;
      WRC_REQ:  if (mem_req_ready)               nextState = WRC_DATA;
      WRC_DATA: if (mem_wdata_ready && lastBeat) nextState = WRC_IDLE;
      default:                                   nextState = WRC_IDLE;
    endcase
  end

  always_comb begin
    mem_req_valid   = state == WRC_REQ;
    mem_wdata_valid = state == WRC_DATA;
    mem_wdata_last  = (state == WRC_DATA) && lastBeat;
    mem_wdata       = (state == WRC_DATA) ? peek[0].data : '0;
    inst_done       = instDone;
    busy            = !fifoEmpty || (state != WRC_IDLE) || (outstanding != '0);
  end

  assign mem_req_addr = reqAddr;
  assign mem_req_len  = reqLen;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      reqAddr     <= '0;
      reqLen      <= '0;
      beatCnt     <= '0;
      outstanding <= '0;
      fence       <= 1'b0;
    end else begin
      if (startReq) begin
        reqAddr <= peek[0].addr;
        reqLen  <= runLen;
        beatCnt <= '0;
      end
      if (wdataFire) beatCnt <= beatCnt + 1'b1;
      if (wdataFire && peek[0].inst) fence <= 1'b1;
      else if (instDone)             fence <= 1'b0;
      unique case ({reqFire, ackAccepted})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  pushWhileFull: assert property (@(posedge clock) disable iff (reset)
    !(pwrite_enable && !pwrite_isWritable && !wdataFire));

  ackWithoutBurst: assert property (@(posedge clock) disable iff (reset)
    !(mem_wr_ack && outstanding == '0));

endmodule

// File: tb/tb_conv_out_write_coalescer.sv
// Directed bench for conv_out_write_coalescer; expectations follow the
// CONV_WR_COALESCE_EN setting of the build.
module tb_conv_out_write_coalescer;

  logic          clock = 1'b0;
  logic          reset;
  logic          pwrite_enable;
  logic [31:0]   pwrite_addr;
  logic [127:0]  pwrite_data;
  logic          pwrite_setNextInst;
  logic          pwrite_isWritable;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic [31:0]   mem_req_addr;
  logic [1:0]    mem_req_len;
  logic          mem_wdata_valid;
  logic          mem_wdata_ready;
  logic [127:0]  mem_wdata;
  logic          mem_wdata_last;
  logic          mem_wr_ack;
  logic          inst_done;
  logic          busy;

  int vecCount  = 0;
  int missCount = 0;
  int cyc       = 0;
  int ackDelay  = 3;
  int beatsSeen = 0;
  int lastAckCyc = -1;
  int firstValidCyc = -1;

  logic [31:0]  reqAddrQ[$];
  logic [1:0]   reqLenQ[$];
  int           reqCycQ[$];
  logic [127:0] beatQ[$];
  logic         lastQ[$];
  int           ackDue[$];
  int           doneCycQ[$];
  logic [31:0]  expAddrQ[$];
  logic [1:0]   expLenQ[$];

  conv_out_write_coalescer dut (
    .clock              (clock),
    .reset              (reset),
    .pwrite_enable      (pwrite_enable),
    .pwrite_addr        (pwrite_addr),
    .pwrite_data        (pwrite_data),
    .pwrite_setNextInst (pwrite_setNextInst),
    .pwrite_isWritable  (pwrite_isWritable),
    .mem_req_valid      (mem_req_valid),
    .mem_req_ready      (mem_req_ready),
    .mem_req_addr       (mem_req_addr),
    .mem_req_len        (mem_req_len),
    .mem_wdata_valid    (mem_wdata_valid),
    .mem_wdata_ready    (mem_wdata_ready),
    .mem_wdata          (mem_wdata),
    .mem_wdata_last     (mem_wdata_last),
    .mem_wr_ack         (mem_wr_ack),
    .inst_done          (inst_done),
    .busy               (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  function automatic logic [127:0] payload(input logic [31:0] a);
    return {8{a[15:0] ^ 16'h5A3C}};
  endfunction

  task automatic checkValue(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vecCount++;
    if (obs !== exp) begin
      missCount++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Handshakes are sampled half a cycle ahead of the edge that completes them.
  always @(negedge clock) begin
    if (!reset) begin
      if (mem_req_valid && mem_req_ready) begin
        reqAddrQ.push_back(mem_req_addr);
        reqLenQ.push_back(mem_req_len);
        reqCycQ.push_back(cyc);
      end
      if (mem_wdata_valid && mem_wdata_ready) begin
        beatQ.push_back(mem_wdata);
        lastQ.push_back(mem_wdata_last);
        beatsSeen++;
        if (mem_wdata_last) ackDue.push_back(cyc + ackDelay);
      end
      if (mem_wr_ack) lastAckCyc = cyc;
      if (inst_done) doneCycQ.push_back(cyc);
      if (mem_req_valid && firstValidCyc < 0) firstValidCyc = cyc;
    end
  end

  always @(posedge clock) begin
    #1;
    if (!reset && ackDue.size() > 0 && ackDue[0] <= cyc) begin
      mem_wr_ack = 1'b1;
      void'(ackDue.pop_front());
    end else begin
      mem_wr_ack = 1'b0;
    end
  end

  task automatic clearMonitors();
    reqAddrQ.delete(); reqLenQ.delete(); reqCycQ.delete();
    beatQ.delete(); lastQ.delete(); doneCycQ.delete();
    expAddrQ.delete(); expLenQ.delete();
    beatsSeen = 0; lastAckCyc = -1; firstValidCyc = -1;
  endtask

  task automatic expReq(input logic [31:0] a, input logic [1:0] l);
    expAddrQ.push_back(a);
    expLenQ.push_back(l);
  endtask

  task automatic pushBeat(input logic [31:0] a, input logic inst);
    pwrite_enable      = 1'b1;
    pwrite_addr        = a;
    pwrite_data        = payload(a);
    pwrite_setNextInst = inst;
    @(posedge clock); #1;
    pwrite_enable      = 1'b0;
    pwrite_setNextInst = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    logic timedOut;
    timedOut = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clock); #2;
      if (!busy && ackDue.size() == 0 && !mem_wr_ack) begin
        timedOut = 1'b0;
        break;
      end
    end
    checkValue({tag, "_drain"}, 128'(timedOut), 128'(0));
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic checkReqs(input string tag);
    int k;
    checkValue({tag, "_nreq"}, 128'(reqAddrQ.size()), 128'(expAddrQ.size()));
    k = 0;
    for (int i = 0; i < expAddrQ.size(); i++) begin
      if (i < reqAddrQ.size()) begin
        checkValue($sformatf("%s_req%0d_addr", tag, i), 128'(reqAddrQ[i]), 128'(expAddrQ[i]));
        checkValue($sformatf("%s_req%0d_len", tag, i), 128'(reqLenQ[i]), 128'(expLenQ[i]));
      end
      for (int j = 0; j <= int'(expLenQ[i]); j++) begin
        if (k < beatQ.size()) begin
          checkValue($sformatf("%s_beat%0d_data", tag, k), beatQ[k], payload(expAddrQ[i] + 32'(j)));
          checkValue($sformatf("%s_beat%0d_last", tag, k), 128'(lastQ[k]), 128'(j == int'(expLenQ[i])));
        end
        k++;
      end
    end
    checkValue({tag, "_nbeat"}, 128'(beatQ.size()), 128'(k));
  endtask

  task automatic checkResetOutputs(input string tag);
    checkValue({tag, "_reqValid"},  128'(mem_req_valid),     128'(0));
    checkValue({tag, "_reqAddr"},   128'(mem_req_addr),      128'(0));
    checkValue({tag, "_reqLen"},    128'(mem_req_len),       128'(0));
    checkValue({tag, "_wdValid"},   128'(mem_wdata_valid),   128'(0));
    checkValue({tag, "_wdata"},     mem_wdata,               128'(0));
    checkValue({tag, "_wdLast"},    128'(mem_wdata_last),    128'(0));
    checkValue({tag, "_instDone"},  128'(inst_done),         128'(0));
    checkValue({tag, "_writable"},  128'(pwrite_isWritable), 128'(1));
    checkValue({tag, "_busy"},      128'(busy),              128'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed no completion expected finish before 500000");
    $fatal(1);
  end

  initial begin
    int pushCyc;
    logic reached;
    reset = 1'b1;
    pwrite_enable = 1'b0; pwrite_addr = '0; pwrite_data = '0; pwrite_setNextInst = 1'b0;
    mem_req_ready = 1'b1; mem_wdata_ready = 1'b1; mem_wr_ack = 1'b0;
    #1;
    checkResetOutputs("por");
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock); #1;

    // Single beat: request two cycles after the push.
    clearMonitors();
    pushCyc = cyc;
    pushBeat(32'h80, 1'b1);
    waitIdle("lat");
    checkValue("lat_cycles", 128'(firstValidCyc - pushCyc), 128'(2));
    expReq(32'h80, 2'd0);
    checkReqs("lat");
    checkValue("lat_ndone", 128'(doneCycQ.size()), 128'(1));

    // Coalesce four contiguous beats of one instruction.
    clearMonitors();
    pushBeat(32'h100, 1'b0); pushBeat(32'h101, 1'b0);
    pushBeat(32'h102, 1'b0); pushBeat(32'h103, 1'b1);
    waitIdle("coal");
`ifdef CONV_WR_COALESCE_EN
    expReq(32'h100, 2'd3);
`else
    expReq(32'h100, 2'd0); expReq(32'h101, 2'd0); expReq(32'h102, 2'd0); expReq(32'h103, 2'd0);
`endif
    checkReqs("coal");
    checkValue("coal_ndone", 128'(doneCycQ.size()), 128'(1));
    if (doneCycQ.size() > 0)
      checkValue("coal_doneLat", 128'(doneCycQ[0]), 128'(lastAckCyc + 1));

    // Address gap splits the run.
    clearMonitors();
    pushBeat(32'h10, 1'b0); pushBeat(32'h11, 1'b0); pushBeat(32'h20, 1'b0);
    waitIdle("gap");
`ifdef CONV_WR_COALESCE_EN
    expReq(32'h10, 2'd1); expReq(32'h20, 2'd0);
`else
    expReq(32'h10, 2'd0); expReq(32'h11, 2'd0); expReq(32'h20, 2'd0);
`endif
    checkReqs("gap");
    checkValue("gap_ndone", 128'(doneCycQ.size()), 128'(0));

    // Bursts never cross an aligned block.
    clearMonitors();
    pushBeat(32'h3, 1'b0); pushBeat(32'h4, 1'b0); pushBeat(32'h5, 1'b0); pushBeat(32'h6, 1'b0);
    waitIdle("align");
`ifdef CONV_WR_COALESCE_EN
    expReq(32'h3, 2'd0); expReq(32'h4, 2'd2);
`else
    expReq(32'h3, 2'd0); expReq(32'h4, 2'd0); expReq(32'h5, 2'd0); expReq(32'h6, 2'd0);
`endif
    checkReqs("align");

    // Fill the FIFO with the request channel stalled.
    clearMonitors();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checkValue($sformatf("bp_writable%0d", i), 128'(pwrite_isWritable), 128'(1));
      pushBeat(32'h40 + 32'(i), 1'b0);
    end
    checkValue("bp_full", 128'(pwrite_isWritable), 128'(0));
    mem_req_ready = 1'b1;
    waitIdle("bp");
`ifdef CONV_WR_COALESCE_EN
    expReq(32'h40, 2'd3); expReq(32'h44, 2'd3);
`else
    for (int i = 0; i < 8; i++) expReq(32'h40 + 32'(i), 2'd0);
`endif
    checkReqs("bp");

    // Instruction B must wait for instruction A's completion.
    clearMonitors();
    ackDelay = 10;
    pushBeat(32'h0, 1'b0); pushBeat(32'h1, 1'b1); pushBeat(32'h2, 1'b1);
    waitIdle("fence");
    ackDelay = 3;
`ifdef CONV_WR_COALESCE_EN
    expReq(32'h0, 2'd1); expReq(32'h2, 2'd0);
`else
    expReq(32'h0, 2'd0); expReq(32'h1, 2'd0); expReq(32'h2, 2'd0);
`endif
    checkReqs("fence");
    checkValue("fence_ndone", 128'(doneCycQ.size()), 128'(2));
    if (doneCycQ.size() > 0 && reqCycQ.size() > 0)
      checkValue("fence_order", 128'(reqCycQ[reqCycQ.size()-1] > doneCycQ[0]), 128'(1));

    // Reset in the middle of data traffic.
    clearMonitors();
    pushBeat(32'h200, 1'b0); pushBeat(32'h201, 1'b0);
    pushBeat(32'h202, 1'b0); pushBeat(32'h203, 1'b0);
    reached = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (beatsSeen >= 2) begin
        reached = 1'b1;
        break;
      end
      @(posedge clock); #2;
    end
    checkValue("rstmid_reached", 128'(reached), 128'(1));
    reset = 1'b1;
    mem_wr_ack = 1'b0;
    ackDue.delete();
    #1;
    checkResetOutputs("rstmid");
    @(posedge clock); #1 reset = 1'b0;
    @(posedge clock); #1;

    // Traffic resumes cleanly after reset.
    clearMonitors();
    pushBeat(32'h300, 1'b1);
    waitIdle("post");
    expReq(32'h300, 2'd0);
    checkReqs("post");
    checkValue("post_ndone", 128'(doneCycQ.size()), 128'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
